alu_unit: RTL

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/alu_unit.sv
// Single-cycle integer ALU feeding a small result FIFO that waits for CDB grants.
// Results are computed at issue and parked in the FIFO until the CDB arbiter accepts them.
`ifndef INSIDE_OPCODE_WIDTH
`define INSIDE_OPCODE_WIDTH 6
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_TAG_WIDTH
`define ROB_TAG_WIDTH 5
`endif
`ifndef ZERO_TAG_ROB
`define ZERO_TAG_ROB 5'd0
`endif
`ifndef OP_ADD
`define OP_ADD  6'd1
`define OP_ADDI 6'd2
`define OP_SUB  6'd3
`define OP_AND  6'd4
`define OP_OR   6'd5
`define OP_XOR  6'd6
`define OP_SLL  6'd7
`define OP_SRL  6'd8
`define OP_SRA  6'd9
`define OP_SLT  6'd10
`define OP_SLTU 6'd11
`define OP_LUI  6'd12
`endif

module alu_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic [`INSIDE_OPCODE_WIDTH-1:0] in_rs_op,
  input  logic [`DATA_WIDTH-1:0]         in_rs_value1,
  input  logic [`DATA_WIDTH-1:0]         in_rs_value2,
  input  logic [`ROB_TAG_WIDTH-1:0]      in_rs_rob_tag,
  output logic                           out_rs_full,
  input  logic                           in_cdb_grant,
  input  logic                           in_rob_clear,
  output logic [`DATA_WIDTH-1:0]         out_cdb_value,
  output logic [`ROB_TAG_WIDTH-1:0]      out_cdb_tag
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [`ROB_TAG_WIDTH-1:0] tag_mem [FIFO_DEPTH];
  logic [`DATA_WIDTH-1:0]    val_mem [FIFO_DEPTH];
  logic [AW-1:0]             head, tail;
  logic [AW:0]               count;
  logic [`DATA_WIDTH-1:0]    result;
  logic                      push, pop, empty;

  always_comb begin
    result = '0;
    case (in_rs_op)
      `OP_ADD, `OP_ADDI: result = in_rs_value1 + in_rs_value2;
      `OP_SUB:  result = in_rs_value1 - in_rs_value2;
      `OP_AND:  result = in_rs_value1 & in_rs_value2;
      `OP_OR:   result = in_rs_value1 | in_rs_value2;
      `OP_XOR:  result = in_rs_value1 ^ in_rs_value2;
      `OP_SLL:  result = in_rs_value1 << in_rs_value2[4:0];
      `OP_SRL:  result = in_rs_value1 >> in_rs_value2[4:0];
      `OP_SRA:  result = $unsigned($signed(in_rs_value1) >>> in_rs_value2[4:0]);
      `OP_SLT:  result = {31'd0, $signed(in_rs_value1) < $signed(in_rs_value2)};
      `OP_SLTU: result = {31'd0, in_rs_value1 < in_rs_value2};
      `OP_LUI:  result = in_rs_value2;
      default:  result = '0;
    endcase
  end

  assign empty       = (count == '0);
  assign out_rs_full = (count == DEPTH_C);
  // Full refuses issue even when a pop frees a slot on the same edge.
  assign push = rdy && (in_rs_rob_tag != `ZERO_TAG_ROB) && !out_rs_full && !in_rob_clear;
  assign pop  = rdy && !empty && in_cdb_grant && !in_rob_clear;

  assign out_cdb_tag   = empty ? `ZERO_TAG_ROB : tag_mem[head];
  assign out_cdb_value = empty ? '0 : val_mem[head];

  // Storage needs no reset: entries outside head..tail are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[tail] <= in_rs_rob_tag;
      val_mem[tail] <= result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (in_rob_clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end
endmodule
